data_ram_slave: RTL and testbench

//  Responder end of the MEM-stage data-memory bus. Decodes ce/we/sel/addr and serves byte, halfword and word

---
 rtl/data_ram_slave_pkg.sv | 17 +
 rtl/data_ram_slave_dram_bank.sv | 33 +++
 rtl/data_ram_slave.sv | 149 ++++++++++++++
 tb/tb_data_ram_slave.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_ram_slave_pkg.sv
// Shared constants and types for the MEM-stage data-memory responder.
package data_ram_slave_pkg;

   localparam logic        rst_enable   = 1'b1;
   localparam logic        chip_enable  = 1'b1;
   localparam logic        write_enable = 1'b1;
   localparam int          reg_w        = 32;
   localparam logic [31:0] zero_word    = 32'h0000_0000;
   localparam int          dram_addr_w  = 10;

   // Responder FSM: IDLE accepts requests, RESP presents load data.
   typedef enum logic {
      st_idle = 1'b0,
      st_resp = 1'b1
   } dram_state_t;

endpackage

// File: rtl/data_ram_slave_dram_bank.sv
// One byte lane of data memory: 8-bit wide, synchronous write and
// synchronous read. The read port only updates when re is high, so the
// output holds the fetched byte while the top module presents it.
import data_ram_slave_pkg::*;

module dram_bank #(
   parameter int ADDR_W = dram_addr_w
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        din,
   output logic [7:0]        dout
);

   logic [7:0] mem [0:(2**ADDR_W)-1];

   // Byte write on the rising edge when enabled.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= din;
      end
   end

   // Registered read, captured only when a load is issued.
   always_ff @(posedge clk) begin
      if (re) begin
         dout <= mem[addr];
      end
   end

endmodule

// File: rtl/data_ram_slave.sv
// Responder end of the MEM-stage data-memory bus. Writes complete with no
// stall; loads stall the pipeline for one cycle (IDLE -> RESP) while the
// synchronous-read RAM returns data. Lanes are big-endian: sel[3] selects
// data[31:24], the byte at address offset 0.
//
// Handshake: a request is taken whenever ce=1 in IDLE. stall_req_o is high
// only in the IDLE cycle of a load. ack_o pulses in the cycle after a request
// is taken (for loads that is the RESP cycle) and err_o pulses with it if
// the address was out of range. Bus inputs are ignored while in RESP.
import data_ram_slave_pkg::*;

module data_ram_slave #(
   parameter int ADDR_W = dram_addr_w
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_ce_i,
   input  logic        mem_we_i,
   input  logic [31:0] mem_addr_i,
   input  logic [3:0]  mem_sel_i,
   input  logic [31:0] mem_data_i,
   output logic [31:0] mem_data_o,
   output logic        stall_req_o,
   output logic        ack_o,
   output logic        err_o,
   output logic        state_o
);

   dram_state_t       state, state_nxt;
   logic [ADDR_W-1:0] idx;
   logic              oor;
   logic              req_rd, req_wr;
   logic [3:0]        bank_we;
   logic              bank_re;
   logic [7:0]        bank_dout [0:3];
   logic [3:0]        sel_q;
   logic              oor_q;
   logic [reg_w-1:0]  resp_word;
   logic [reg_w-1:0]  data_q;
   logic              unused_addr_lsb;

   // Byte offset is carried by sel, so the two address LSBs are not decoded.
   assign unused_addr_lsb = ^mem_addr_i[1:0];

   assign idx     = mem_addr_i[ADDR_W+1:2];
   assign oor     = |mem_addr_i[31:ADDR_W+2];
   assign req_rd  = (state == st_idle) && (mem_ce_i == chip_enable) && (mem_we_i != write_enable);
   assign req_wr  = (state == st_idle) && (mem_ce_i == chip_enable) && (mem_we_i == write_enable);
   assign bank_re = (rst != rst_enable) && req_rd;
   assign state_o = state;

   // Per-lane write enables; out-of-range and reset cycles never commit.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         bank_we[i] = (rst != rst_enable) && req_wr && !oor && mem_sel_i[i];
      end
   end

   genvar g;
   generate
      for (g = 0; g < 4; g++) begin : g_lane
         dram_bank #(.ADDR_W(ADDR_W)) u_bank (
            .clk  (clk),
            .we   (bank_we[g]),
            .re   (bank_re),
            .addr (idx),
            .din  (mem_data_i[8*g +: 8]),
            .dout (bank_dout[g])
         );
      end
   endgenerate

   // State register.
   always_ff @(posedge clk) begin
      if (rst == rst_enable) begin
         state <= st_idle;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and the combinational stall request.
   always_comb begin
      state_nxt   = state;
      stall_req_o = 1'b0;
      case (state)
         st_idle: begin
            if (req_rd) begin
               stall_req_o = 1'b1;
               state_nxt   = st_resp;
            end
         end
         st_resp: begin
            state_nxt = st_idle;
         end
         default: begin
            state_nxt = st_idle;
         end
      endcase
      if (rst == rst_enable) begin
         stall_req_o = 1'b0;
      end
   end

   // Remember lane selects and range flag of the load being served.
   always_ff @(posedge clk) begin
      if (rst == rst_enable) begin
         sel_q <= 4'b0000;
         oor_q <= 1'b0;
      end else if (req_rd) begin
         sel_q <= mem_sel_i;
         oor_q <= oor;
      end
   end

   // Completion pulse one cycle after any accepted request.
   always_ff @(posedge clk) begin
      if (rst == rst_enable) begin
         ack_o <= 1'b0;
         err_o <= 1'b0;
      end else begin
         ack_o <= (state == st_idle) && (mem_ce_i == chip_enable);
         err_o <= (state == st_idle) && (mem_ce_i == chip_enable) && oor;
      end
   end

   // Masked load word: unselected lanes and out-of-range loads read as zero.
   always_comb begin
      resp_word = zero_word;
      for (int i = 0; i < 4; i++) begin
         if (sel_q[i] && !oor_q) begin
            resp_word[8*i +: 8] = bank_dout[i];
         end
      end
   end

   // Hold the last completed load once RESP is left.
   always_ff @(posedge clk) begin
      if (rst == rst_enable) begin
         data_q <= zero_word;
      end else if (state == st_resp) begin
         data_q <= resp_word;
      end
   end

   // RAM data is visible as soon as RESP is entered, then held by data_q.
   assign mem_data_o = (state == st_resp) ? resp_word : data_q;

endmodule

// File: tb/tb_data_ram_slave.sv
// Bench for data_ram_slave: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level memory model.
module tb_data_ram_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_ce_i = 1'b0;
   logic        mem_we_i = 1'b0;
   logic [31:0] mem_addr_i = 32'h0;
   logic [3:0]  mem_sel_i = 4'h0;
   logic [31:0] mem_data_i = 32'h0;
   logic [31:0] mem_data_o;
   logic        stall_req_o;
   logic        ack_o;
   logic        err_o;
   logic        state_o;

   int tests = 0;
   int fails = 0;

   // Model state.
   logic [31:0] model [0:1023];
   logic        pend_ack = 1'b0;
   logic        pend_err = 1'b0;
   logic [31:0] last_rd  = 32'h0;
   logic        chk_en   = 1'b0;
   logic        exp_stall, exp_ack, exp_err;
   logic [31:0] exp_data;
   logic [31:0] exp_q [$];

   data_ram_slave #(.ADDR_W(10)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_ce_i    (mem_ce_i),
      .mem_we_i    (mem_we_i),
      .mem_addr_i  (mem_addr_i),
      .mem_sel_i   (mem_sel_i),
      .mem_data_i  (mem_data_i),
      .mem_data_o  (mem_data_o),
      .stall_req_o (stall_req_o),
      .ack_o       (ack_o),
      .err_o       (err_o),
      .state_o     (state_o)
   );

   // Clock.
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Compare process: every cycle, away from the rising edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("stall", {31'b0, stall_req_o}, {31'b0, exp_stall});
         check("ack",   {31'b0, ack_o},       {31'b0, exp_ack});
         check("err",   {31'b0, err_o},       {31'b0, exp_err});
         check("data",  mem_data_o,           exp_data);
      end
   end

   function automatic logic [31:0] lane_mask(input logic [3:0] sel);
      logic [31:0] m = 32'h0;
      for (int i = 0; i < 4; i++) if (sel[i]) m[8*i +: 8] = 8'hFF;
      return m;
   endfunction

   function automatic logic out_of_range(input logic [31:0] addr);
      return addr >= 32'h0000_1000;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_bus(input logic ce, input logic we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] data);
      mem_ce_i   = ce;
      mem_we_i   = we;
      mem_addr_i = addr;
      mem_sel_i  = sel;
      mem_data_i = data;
   endtask

   task automatic expect_cycle(input logic stall, input logic ack, input logic err, input logic [31:0] data);
      exp_stall = stall;
      exp_ack   = ack;
      exp_err   = err;
      exp_data  = data;
   endtask

   task automatic idle_cycle();
      set_bus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      expect_cycle(1'b0, pend_ack, pend_err, last_rd);
      tick();
      pend_ack = 1'b0;
      pend_err = 1'b0;
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
      logic [31:0] m;
      set_bus(1'b1, 1'b1, addr, sel, data);
      expect_cycle(1'b0, pend_ack, pend_err, last_rd);
      tick();
      if (!out_of_range(addr)) begin
         m = lane_mask(sel);
         model[addr[11:2]] = (model[addr[11:2]] & ~m) | (data & m);
      end
      pend_ack = 1'b1;
      pend_err = out_of_range(addr);
      set_bus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
   endtask

   // Load: IDLE cycle with stall, then RESP cycle. Optionally reset in RESP.
   task automatic bus_read(input logic [31:0] addr, input logic [3:0] sel, input logic lit_en,
                           input logic [31:0] lit, input logic rst_in_resp);
      logic [31:0] rd;
      set_bus(1'b1, 1'b0, addr, sel, 32'h0);
      expect_cycle(1'b1, pend_ack, pend_err, last_rd);
      tick();
      rd = out_of_range(addr) ? 32'h0 : (model[addr[11:2]] & lane_mask(sel));
      exp_q.push_back(rd);
      rst = rst_in_resp;
      expect_cycle(1'b0, 1'b1, out_of_range(addr), rd);
      if (lit_en) begin
         @(negedge clk);
         check("load_literal", mem_data_o, lit);
         check("model_literal", rd, lit);
      end
      tick();
      rst = 1'b0;
      pend_ack = 1'b0;
      pend_err = 1'b0;
      last_rd  = rst_in_resp ? 32'h0 : exp_q.pop_front();
      if (rst_in_resp) void'(exp_q.pop_front());
      set_bus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
   endtask

   task automatic lit_ack(input logic a, input logic e);
      check("ack_literal", {31'b0, ack_o}, {31'b0, a});
      check("err_literal", {31'b0, err_o}, {31'b0, e});
   endtask

   initial begin
      logic [31:0] addr, data;
      logic [3:0]  sel;
      int          op;

      // Reset.
      rst = 1'b1;
      expect_cycle(1'b0, 1'b0, 1'b0, 32'h0);
      tick(); tick();
      set_bus(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
      #1;
      check("reset_stall", {31'b0, stall_req_o}, 32'h0);
      check("reset_data", mem_data_o, 32'h0);
      lit_ack(1'b0, 1'b0);
      set_bus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      tick();
      rst    = 1'b0;
      chk_en = 1'b1;

      // Word write then load.
      bus_write(32'h10, 32'h1122_3344, 4'b1111);
      lit_ack(1'b1, 1'b0);
      bus_read(32'h10, 4'b1111, 1'b1, 32'h1122_3344, 1'b0);

      // Byte and halfword lanes.
      bus_write(32'h11, 32'h5555_5555, 4'b0100);
      bus_read(32'h10, 4'b1111, 1'b1, 32'h1155_3344, 1'b0);
      bus_read(32'h10, 4'b0100, 1'b1, 32'h0055_0000, 1'b0);
      bus_write(32'h12, 32'hBEEF_BEEF, 4'b0011);
      bus_read(32'h10, 4'b1111, 1'b1, 32'h1155_BEEF, 1'b0);
      bus_write(32'h11, 32'h1234_5678, 4'b0000);
      lit_ack(1'b1, 1'b0);
      bus_read(32'h10, 4'b1111, 1'b1, 32'h1155_BEEF, 1'b0);
      bus_read(32'h10, 4'b0000, 1'b1, 32'h0000_0000, 1'b0);

      // Back-to-back loads.
      bus_write(32'h14, 32'hCAFE_F00D, 4'b1111);
      idle_cycle();
      bus_read(32'h10, 4'b1111, 1'b1, 32'h1155_BEEF, 1'b0);
      bus_read(32'h14, 4'b1111, 1'b1, 32'hCAFE_F00D, 1'b0);

      // Out of range, no aliasing onto word 0.
      bus_write(32'h0, 32'h0102_0304, 4'b1111);
      bus_write(32'h1000, 32'hDEAD_BEEF, 4'b1111);
      lit_ack(1'b1, 1'b1);
      bus_read(32'h1000, 4'b1111, 1'b1, 32'h0, 1'b0);
      bus_read(32'h0, 4'b1111, 1'b1, 32'h0102_0304, 1'b0);

      // Reset during RESP abandons the load but keeps RAM.
      bus_read(32'h10, 4'b1111, 1'b0, 32'h0, 1'b1);
      check("rst_resp_data", mem_data_o, 32'h0);
      lit_ack(1'b0, 1'b0);
      bus_read(32'h10, 4'b1111, 1'b1, 32'h1155_BEEF, 1'b0);

      // Fill a small window so random loads always hit known data.
      for (int w = 0; w < 16; w++) bus_write(w << 2, $urandom, 4'b1111);

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         op   = $urandom_range(0, 19);
         addr = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         if ($urandom_range(0, 7) == 0) addr = addr | 32'h1000 | ($urandom_range(0, 3) << 20);
         sel  = 4'($urandom_range(0, 15));
         data = $urandom;
         if (op < 8)       bus_write(addr, data, sel);
         else if (op < 17) bus_read(addr, sel, 1'b0, 32'h0, 1'b0);
         else if (op < 19) idle_cycle();
         else              bus_read(addr, sel, 1'b0, 32'h0, 1'b1);
      end

      idle_cycle();
      idle_cycle();
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
